// File: rtl/bus_resp_ctrl_if.sv
// CPU data-port and peripheral-side signals of the bus responder.
// The design uses the slave modport; the CPU/peripheral model uses the master modport.
interface bus_resp_ctrl_if;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [31:0] s_addr;
    logic        s_we;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s0_req_plic;
    logic        s1_req_gpio;
    logic        s3_req_uart;
    logic        s0_ack;
    logic        s1_ack;
    logic        s3_ack;
    logic [31:0] s0_rdata;
    logic [31:0] s1_rdata;
    logic [31:0] s3_rdata;

    modport slave (
        input  m_req, m_addr, m_we, m_wdata, m_wstrb,
        input  s0_ack, s1_ack, s3_ack, s0_rdata, s1_rdata, s3_rdata,
        output m_ready, m_rvalid, m_rdata, m_err,
        output s_addr, s_we, s_wdata, s_wstrb,
        output s0_req_plic, s1_req_gpio, s3_req_uart
    );

    modport master (
        output m_req, m_addr, m_we, m_wdata, m_wstrb,
        output s0_ack, s1_ack, s3_ack, s0_rdata, s1_rdata, s3_rdata,
        input  m_ready, m_rvalid, m_rdata, m_err,
        input  s_addr, s_we, s_wdata, s_wstrb,
        input  s0_req_plic, s1_req_gpio, s3_req_uart
    );
endinterface

// File: rtl/bus_resp_ctrl.sv
// CPU data-port responder: decodes addr[31:28], forwards to PLIC/GPIO/UART, returns one-cycle response.
// Optional macro BUS_TIMEOUT_EN adds a WAIT-state timeout that completes stalled accesses with an error.
module bus_resp_ctrl #(
    parameter logic [3:0] PLIC_REGION = 4'h3,
    parameter logic [3:0] GPIO_REGION = 4'h4,
    parameter logic [3:0] UART_REGION = 4'h6
`ifdef BUS_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_resp_ctrl_if.slave bus
);
    localparam int unsigned SelW  = 3;
    localparam int unsigned DataW = 32;
`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CntW  = 16;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e            state_q;
    logic [SelW-1:0]   sel_q;
    logic [SelW-1:0]   req_q;
    logic              ready_q;
    logic              rvalid_q;
    logic [DataW-1:0]  rdata_q;
    logic              err_q;
    logic [31:0]       s_addr_q;
    logic              s_we_q;
    logic [DataW-1:0]  s_wdata_q;
    logic [3:0]        s_wstrb_q;
`ifdef BUS_TIMEOUT_EN
    logic [CntW-1:0]   cnt_q;
`endif

    logic [SelW-1:0]   dec_sel_c;
    logic              ack_sel_c;
    logic [DataW-1:0]  sel_rdata_c;

    // One-hot select: bit0 PLIC, bit1 GPIO, bit2 UART; zero means unmapped.
    always_comb begin
        dec_sel_c = '0;
        if (bus.m_addr[31:28] == PLIC_REGION)      dec_sel_c = 3'b001;
        else if (bus.m_addr[31:28] == GPIO_REGION) dec_sel_c = 3'b010;
        else if (bus.m_addr[31:28] == UART_REGION) dec_sel_c = 3'b100;
    end

    assign ack_sel_c   = |(sel_q & {bus.s3_ack, bus.s1_ack, bus.s0_ack});
    assign sel_rdata_c = ({DataW{sel_q[0]}} & bus.s0_rdata)
                       | ({DataW{sel_q[1]}} & bus.s1_rdata)
                       | ({DataW{sel_q[2]}} & bus.s3_rdata);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            req_q     <= '0;
            ready_q   <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            s_addr_q  <= '0;
            s_we_q    <= 1'b0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    rvalid_q <= 1'b0;
                    if (bus.m_req) begin
                        s_addr_q  <= bus.m_addr;
                        s_we_q    <= bus.m_we;
                        s_wdata_q <= bus.m_wdata;
                        s_wstrb_q <= bus.m_wstrb;
                        sel_q     <= dec_sel_c;
                        ready_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                        if (dec_sel_c != '0) begin
                            req_q   <= dec_sel_c;
                            state_q <= WAIT;
                        end else begin
                            rdata_q  <= '0;
                            err_q    <= 1'b1;
                            rvalid_q <= 1'b1;
                            state_q  <= RESP;
                        end
                    end
                end
                WAIT: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (ack_sel_c) begin
                        req_q    <= '0;
                        rdata_q  <= s_we_q ? '0 : sel_rdata_c;
                        err_q    <= 1'b0;
                        rvalid_q <= 1'b1;
                        state_q  <= RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        req_q    <= '0;
                        rdata_q  <= '0;
                        err_q    <= 1'b1;
                        rvalid_q <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
`endif
                end
                RESP: begin
                    rvalid_q <= 1'b0;
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.m_ready     = ready_q;
    assign bus.m_rvalid    = rvalid_q;
    assign bus.m_rdata     = rdata_q;
    assign bus.m_err       = err_q;
    assign bus.s_addr      = s_addr_q;
    assign bus.s_we        = s_we_q;
    assign bus.s_wdata     = s_wdata_q;
    assign bus.s_wstrb     = s_wstrb_q;
    assign bus.s0_req_plic = req_q[0];
    assign bus.s1_req_gpio = req_q[1];
    assign bus.s3_req_uart = req_q[2];
endmodule

// File: tb/tb_bus_resp_ctrl.sv
// Directed bench for bus_resp_ctrl; build with BUS_TIMEOUT_EN to exercise the timeout path (TIMEOUT_CYCLES=8).
`timescale 1ns/1ps
module tb_bus_resp_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tie_uart = 1'b0;
    logic s3_ack_drv = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   c_req0 = 0, c_req1 = 0, c_req3 = 0, c_rv = 0;

    bus_resp_ctrl_if bus ();

    assign bus.s3_ack = tie_uart ? bus.s3_req_uart : s3_ack_drv;

`ifdef BUS_TIMEOUT_EN
    bus_resp_ctrl #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
`else
    bus_resp_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

    always #5 clk = ~clk;

    // Cycle-level activity counters sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.s0_req_plic) c_req0 <= c_req0 + 1;
        if (bus.s1_req_gpio) c_req1 <= c_req1 + 1;
        if (bus.s3_req_uart) c_req3 <= c_req3 + 1;
        if (bus.m_rvalid)    c_rv   <= c_rv + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wd, input logic [3:0] ws);
        bus.m_req = 1'b1; bus.m_addr = addr; bus.m_we = we; bus.m_wdata = wd; bus.m_wstrb = ws;
        tick();
        bus.m_req = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_tests++; if (bus.m_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", bus.m_ready); end
        n_tests++; if (bus.m_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %b want 0", bus.m_rvalid); end
        n_tests++; if ({bus.s0_req_plic, bus.s1_req_gpio, bus.s3_req_uart} !== 3'b000) begin n_fail++;
            $display("FAIL rst_reqs got %b want 000", {bus.s0_req_plic, bus.s1_req_gpio, bus.s3_req_uart}); end
        n_tests++; if ({bus.s_addr, bus.s_wdata, bus.m_rdata} !== 96'h0) begin n_fail++;
            $display("FAIL rst_regs got %h want 0", {bus.s_addr, bus.s_wdata, bus.m_rdata}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_gpio_read();
        int r1;
        r1 = c_req1;
        issue(32'h4000_0008, 1'b0, 32'h0, 4'hF);
        n_tests++; if (bus.s_addr !== 32'h4000_0008) begin n_fail++; $display("FAIL rd_saddr got %h want 40000008", bus.s_addr); end
        n_tests++; if (bus.s_we !== 1'b0) begin n_fail++; $display("FAIL rd_swe got %b want 0", bus.s_we); end
        n_tests++; if (bus.m_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_wait got %b want 0", bus.m_ready); end
        tick(); tick();
        bus.s1_ack = 1'b1; bus.s1_rdata = 32'h0000_00A5;
        tick();
        bus.s1_ack = 1'b0; bus.s1_rdata = 32'h0;
        n_tests++; if (bus.m_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid got %b want 1", bus.m_rvalid); end
        n_tests++; if (bus.m_rdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL rd_rdata got %h want 000000a5", bus.m_rdata); end
        n_tests++; if (bus.m_err !== 1'b0) begin n_fail++; $display("FAIL rd_err got %b want 0", bus.m_err); end
        tick();
        n_tests++; if (c_req1 - r1 !== 3) begin n_fail++; $display("FAIL rd_req_cycles got %0d want 3", c_req1 - r1); end
        n_tests++; if ({bus.m_rvalid, bus.m_ready} !== 2'b01) begin n_fail++; $display("FAIL rd_after got rv/rdy %b want 01", {bus.m_rvalid, bus.m_ready}); end
        n_tests++; if (bus.m_rdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL rd_hold got %h want 000000a5", bus.m_rdata); end
    endtask

    task automatic test_uart_write_comb();
        int r3;
        tie_uart = 1'b1;
        r3 = c_req3;
        issue(32'h6000_0000, 1'b1, 32'h0000_0041, 4'b0001);
        n_tests++; if ({bus.s_we, bus.s_wstrb, bus.s_wdata} !== {1'b1, 4'b0001, 32'h41}) begin n_fail++;
            $display("FAIL wr_sregs got we %b strb %b wd %h want 1 0001 00000041", bus.s_we, bus.s_wstrb, bus.s_wdata); end
        n_tests++; if (bus.m_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_rvalid_early got %b want 0", bus.m_rvalid); end
        tick();
        n_tests++; if ({bus.m_rvalid, bus.m_err, bus.m_rdata} !== {2'b10, 32'h0}) begin n_fail++;
            $display("FAIL wr_resp got rv %b err %b rd %h want 1 0 0", bus.m_rvalid, bus.m_err, bus.m_rdata); end
        tick();
        n_tests++; if (c_req3 - r3 !== 1) begin n_fail++; $display("FAIL wr_req_cycles got %0d want 1", c_req3 - r3); end
        tie_uart = 1'b0;
    endtask

    task automatic test_unmapped();
        int r0, r1, r3;
        r0 = c_req0; r1 = c_req1; r3 = c_req3;
        issue(32'h5000_0010, 1'b0, 32'h0, 4'hF);
        n_tests++; if ({bus.m_rvalid, bus.m_err, bus.m_rdata} !== {2'b11, 32'h0}) begin n_fail++;
            $display("FAIL um_resp got rv %b err %b rd %h want 1 1 0", bus.m_rvalid, bus.m_err, bus.m_rdata); end
        tick();
        n_tests++; if ({bus.m_ready, bus.m_rvalid} !== 2'b10) begin n_fail++; $display("FAIL um_after got rdy/rv %b want 10", {bus.m_ready, bus.m_rvalid}); end
        tick();
        n_tests++; if ((c_req0 - r0) + (c_req1 - r1) + (c_req3 - r3) !== 0) begin n_fail++;
            $display("FAIL um_no_req got %0d req cycles want 0", (c_req0 - r0) + (c_req1 - r1) + (c_req3 - r3)); end
    endtask

    task automatic test_stray_ack();
        int rv;
        rv = c_rv;
        bus.s1_ack = 1'b1; bus.s1_rdata = 32'hFFFF_FFFF;
        tick();
        bus.s1_ack = 1'b0;
        n_tests++; if ({bus.m_ready, c_rv - rv} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL idle_ack got rdy %b rv_cycles %0d want 1 0", bus.m_ready, c_rv - rv); end
        issue(32'h4000_0020, 1'b0, 32'h0, 4'hF);
        bus.s0_ack = 1'b1; s3_ack_drv = 1'b1; bus.s0_rdata = 32'hDEAD_0000; bus.s3_rdata = 32'h0000_BEEF;
        tick();
        bus.s0_ack = 1'b0; s3_ack_drv = 1'b0;
        n_tests++; if ({bus.s1_req_gpio, bus.m_rvalid} !== 2'b10) begin n_fail++; $display("FAIL stray_wait got req/rv %b want 10", {bus.s1_req_gpio, bus.m_rvalid}); end
        bus.s1_ack = 1'b1; bus.s1_rdata = 32'h1234_5678;
        tick();
        bus.s1_ack = 1'b0;
        n_tests++; if ({bus.m_rvalid, bus.m_err, bus.m_rdata} !== {2'b10, 32'h1234_5678}) begin n_fail++;
            $display("FAIL stray_resp got rv %b err %b rd %h want 1 0 12345678", bus.m_rvalid, bus.m_err, bus.m_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        int r3, rv;
        tie_uart = 1'b1;
        r3 = c_req3; rv = c_rv;
        bus.m_req = 1'b1; bus.m_addr = 32'h6000_0004; bus.m_we = 1'b1; bus.m_wdata = 32'h55; bus.m_wstrb = 4'h1;
        for (int i = 0; i < 9; i++) tick();
        bus.m_req = 1'b0;
        n_tests++; if (c_rv - rv !== 3) begin n_fail++; $display("FAIL b2b_rvalid got %0d want 3", c_rv - rv); end
        n_tests++; if (c_req3 - r3 !== 3) begin n_fail++; $display("FAIL b2b_req got %0d want 3", c_req3 - r3); end
        tick();
        n_tests++; if ({bus.m_ready, bus.m_rvalid} !== 2'b10) begin n_fail++; $display("FAIL b2b_idle got rdy/rv %b want 10", {bus.m_ready, bus.m_rvalid}); end
        tie_uart = 1'b0;
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        int hi, rv;
        hi = 0;
        issue(32'h3000_0004, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 20 && !bus.m_rvalid; i++) begin
            if (bus.s0_req_plic) hi++;
            tick();
        end
        n_tests++; if (hi !== 8) begin n_fail++; $display("FAIL to_req_cycles got %0d want 8", hi); end
        n_tests++; if ({bus.m_rvalid, bus.m_err, bus.m_rdata, bus.s0_req_plic} !== {2'b11, 32'h0, 1'b0}) begin n_fail++;
            $display("FAIL to_resp got rv %b err %b rd %h req %b want 1 1 0 0", bus.m_rvalid, bus.m_err, bus.m_rdata, bus.s0_req_plic); end
        rv = c_rv;
        for (int i = 0; i < 4; i++) tick();
        bus.s0_ack = 1'b1; bus.s0_rdata = 32'hCAFE_CAFE;
        tick();
        bus.s0_ack = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_tests++; if ({bus.m_ready, c_rv - rv} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL to_late_ack got rdy %b rv_cycles %0d want 1 0", bus.m_ready, c_rv - rv); end
    endtask

    task automatic test_ack_wins();
        issue(32'h3000_0008, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 7; i++) tick();
        n_tests++; if (bus.s0_req_plic !== 1'b1) begin n_fail++; $display("FAIL aw_req got %b want 1", bus.s0_req_plic); end
        bus.s0_ack = 1'b1; bus.s0_rdata = 32'h0BAD_F00D;
        tick();
        bus.s0_ack = 1'b0;
        n_tests++; if ({bus.m_rvalid, bus.m_err, bus.m_rdata} !== {2'b10, 32'h0BAD_F00D}) begin n_fail++;
            $display("FAIL aw_resp got rv %b err %b rd %h want 1 0 0badf00d", bus.m_rvalid, bus.m_err, bus.m_rdata); end
        tick();
    endtask
`else
    task automatic test_no_timeout();
        int hi;
        hi = 0;
        issue(32'h3000_0004, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 300; i++) begin
            if (bus.s0_req_plic && !bus.m_rvalid && !bus.m_ready) hi++;
            tick();
        end
        n_tests++; if (hi !== 300) begin n_fail++; $display("FAIL nto_wait got %0d want 300", hi); end
        bus.s0_ack = 1'b1; bus.s0_rdata = 32'h0000_7777;
        tick();
        bus.s0_ack = 1'b0;
        n_tests++; if ({bus.m_rvalid, bus.m_err, bus.m_rdata} !== {2'b10, 32'h0000_7777}) begin n_fail++;
            $display("FAIL nto_resp got rv %b err %b rd %h want 1 0 00007777", bus.m_rvalid, bus.m_err, bus.m_rdata); end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        int rv;
        issue(32'h4000_000C, 1'b0, 32'hFFFF_FFFF, 4'hF);
        n_tests++; if (bus.s1_req_gpio !== 1'b1) begin n_fail++; $display("FAIL rm_wait got %b want 1", bus.s1_req_gpio); end
        rv = c_rv;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({bus.s1_req_gpio, bus.m_rvalid, bus.m_ready} !== 3'b001) begin n_fail++;
            $display("FAIL rm_outs got req/rv/rdy %b want 001", {bus.s1_req_gpio, bus.m_rvalid, bus.m_ready}); end
        n_tests++; if ({bus.s_addr, bus.s_we, bus.s_wdata, bus.s_wstrb} !== 69'h0) begin n_fail++;
            $display("FAIL rm_sregs got %h %b %h %h want 0", bus.s_addr, bus.s_we, bus.s_wdata, bus.s_wstrb); end
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++; if (c_rv - rv !== 0) begin n_fail++; $display("FAIL rm_no_rvalid got %0d want 0", c_rv - rv); end
        issue(32'h4000_0000, 1'b0, 32'h0, 4'hF);
        bus.s1_ack = 1'b1; bus.s1_rdata = 32'h0000_5A5A;
        tick();
        bus.s1_ack = 1'b0;
        n_tests++; if ({bus.m_rvalid, bus.m_err, bus.m_rdata} !== {2'b10, 32'h0000_5A5A}) begin n_fail++;
            $display("FAIL rm_after got rv %b err %b rd %h want 1 0 00005a5a", bus.m_rvalid, bus.m_err, bus.m_rdata); end
        tick();
    endtask

    initial begin
        bus.m_req = 1'b0; bus.m_addr = '0; bus.m_we = 1'b0; bus.m_wdata = '0; bus.m_wstrb = '0;
        bus.s0_ack = 1'b0; bus.s1_ack = 1'b0;
        bus.s0_rdata = '0; bus.s1_rdata = '0; bus.s3_rdata = '0;
        test_reset();
        test_gpio_read();
        test_uart_write_comb();
        test_unmapped();
        test_stray_ack();
        test_back_to_back();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
        test_ack_wins();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
